// File: rtl/alu_issue_ctrl_if.sv
// alu_issue_ctrl_if
//   Bundles every non-clock signal of the ALU issue/capture stage.
//   Three groups share the bundle:
//     - Upstream instruction slice: IN_VALID/IN_READY handshake, OPCODE, FUNCT,
//       SHAMT_IN, RS_VAL, RT_VAL, IMM.
//     - ALU side: registered drive (ALU_A, ALU_B, ALU_CNRL, ALU_SHAMT) and the
//       ALU's combinational answer (ALU_RESULT, ALU_ZF/NF/OF/BF).
//     - Downstream result: OUT_VALID/OUT_READY handshake, RESULT, ZF, NF, TRAP,
//       ILLEGAL.
//   Modports:
//     slave  - the issue stage itself.
//     master - its environment (decode stage, ALU and writeback together).
interface alu_issue_ctrl_if;
    logic        IN_VALID;
    logic        IN_READY;
    logic [5:0]  OPCODE;
    logic [5:0]  FUNCT;
    logic [4:0]  SHAMT_IN;
    logic [31:0] RS_VAL;
    logic [31:0] RT_VAL;
    logic [15:0] IMM;

    logic [31:0] ALU_A;
    logic [31:0] ALU_B;
    logic [3:0]  ALU_CNRL;
    logic [4:0]  ALU_SHAMT;
    logic [31:0] ALU_RESULT;
    logic        ALU_ZF;
    logic        ALU_NF;
    logic        ALU_OF;
    logic        ALU_BF;

    logic        OUT_VALID;
    logic        OUT_READY;
    logic [31:0] RESULT;
    logic        ZF;
    logic        NF;
    logic        TRAP;
    logic        ILLEGAL;

    modport slave (
        input  IN_VALID, OPCODE, FUNCT, SHAMT_IN, RS_VAL, RT_VAL, IMM,
        output IN_READY,
        output ALU_A, ALU_B, ALU_CNRL, ALU_SHAMT,
        input  ALU_RESULT, ALU_ZF, ALU_NF, ALU_OF, ALU_BF,
        output OUT_VALID, RESULT, ZF, NF, TRAP, ILLEGAL,
        input  OUT_READY
    );

    modport master (
        output IN_VALID, OPCODE, FUNCT, SHAMT_IN, RS_VAL, RT_VAL, IMM,
        input  IN_READY,
        input  ALU_A, ALU_B, ALU_CNRL, ALU_SHAMT,
        output ALU_RESULT, ALU_ZF, ALU_NF, ALU_OF, ALU_BF,
        input  OUT_VALID, RESULT, ZF, NF, TRAP, ILLEGAL,
        output OUT_READY
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl
//   Issue and capture stage around a 32-bit combinational ALU.
//   S1 decodes an accepted MIPS instruction slice into registered ALU drive
//   (A, B, CNRL, SHAMT) plus trap-enable and illegal markers. S2 captures the
//   ALU's answer one cycle later into the result register.
// Ports:
//   CLK    - rising-edge clock
//   RST_N  - asynchronous, active-low reset
//   bus    - alu_issue_ctrl_if.slave: input slice, ALU drive/answer, result
//
// Handshakes (both sides): a transfer happens on a rising edge where valid and
// ready are both high. A producer holds valid and its data stable until the
// transfer. IN_READY is derived only from stage occupancy and OUT_READY, never
// from IN_VALID, so it is safe to use as a pure function of downstream state.
module alu_issue_ctrl (
    input  logic            CLK,
    input  logic            RST_N,
    alu_issue_ctrl_if.slave bus
);
    localparam logic [3:0] CNRL_ILLEGAL = 4'b1111;

    // S1 state
    logic        s1_valid;
    logic        s1_trap_en;
    logic        s1_illegal;
    logic [31:0] alu_a_q;
    logic [31:0] alu_b_q;
    logic [3:0]  alu_cnrl_q;
    logic [4:0]  alu_shamt_q;

    // S2 state
    logic        out_valid_q;
    logic [31:0] result_q;
    logic        zf_q;
    logic        nf_q;
    logic        trap_q;
    logic        illegal_q;

    // Flow control
    logic        s2_free;
    logic        s1_adv;
    logic        in_fire;

    // Decode results
    logic [31:0] dec_a;
    logic [31:0] dec_b;
    logic [3:0]  dec_cnrl;
    logic [4:0]  dec_shamt;
    logic        dec_trap_en;
    logic        dec_illegal;
    logic [31:0] imm_sext;
    logic [31:0] imm_zext;

    logic        cap_illegal;

    assign s2_free = !out_valid_q || bus.OUT_READY;
    assign s1_adv  = s1_valid && s2_free;
    assign in_fire = bus.IN_VALID && bus.IN_READY;

    assign bus.IN_READY = !s1_valid || s2_free;

    assign imm_sext = {{16{bus.IMM[15]}}, bus.IMM};
    assign imm_zext = {16'h0000, bus.IMM};

    // Opcode/funct decode. Unknown encodings keep the R-type operand routing
    // and carry CNRL=1111, which the ALU also reports as a bad function.
    always_comb begin
        dec_a       = bus.RS_VAL;
        dec_b       = bus.RT_VAL;
        dec_shamt   = bus.SHAMT_IN;
        dec_cnrl    = CNRL_ILLEGAL;
        dec_trap_en = 1'b0;
        dec_illegal = 1'b0;

        if (bus.OPCODE == 6'h00) begin
            case (bus.FUNCT)
                6'h20: begin dec_cnrl = 4'b0010; dec_trap_en = 1'b1; end
                6'h21: dec_cnrl = 4'b0010;
                6'h22: begin dec_cnrl = 4'b0110; dec_trap_en = 1'b1; end
                6'h23: dec_cnrl = 4'b0110;
                6'h24: dec_cnrl = 4'b0000;
                6'h25: dec_cnrl = 4'b0001;
                6'h26: dec_cnrl = 4'b0011;
                6'h27: dec_cnrl = 4'b0100;
                6'h2A: dec_cnrl = 4'b0111;
                6'h2B: dec_cnrl = 4'b0101;
                6'h00: dec_cnrl = 4'b1000;
                6'h02: dec_cnrl = 4'b1010;
                6'h03: dec_cnrl = 4'b1100;
                // Variable shifts: the ALU takes the shift count from A.
                6'h04: begin dec_cnrl = 4'b1001; dec_a = {27'b0, bus.RS_VAL[4:0]}; end
                6'h06: begin dec_cnrl = 4'b1011; dec_a = {27'b0, bus.RS_VAL[4:0]}; end
                6'h07: begin dec_cnrl = 4'b1101; dec_a = {27'b0, bus.RS_VAL[4:0]}; end
                default: dec_illegal = 1'b1;
            endcase
        end else begin
            case (bus.OPCODE)
                6'h08: begin dec_cnrl = 4'b0010; dec_b = imm_sext; dec_shamt = 5'd0; dec_trap_en = 1'b1; end
                6'h09: begin dec_cnrl = 4'b0010; dec_b = imm_sext; dec_shamt = 5'd0; end
                6'h0A: begin dec_cnrl = 4'b0111; dec_b = imm_sext; dec_shamt = 5'd0; end
                6'h0B: begin dec_cnrl = 4'b0101; dec_b = imm_sext; dec_shamt = 5'd0; end
                6'h0C: begin dec_cnrl = 4'b0000; dec_b = imm_zext; dec_shamt = 5'd0; end
                6'h0D: begin dec_cnrl = 4'b0001; dec_b = imm_zext; dec_shamt = 5'd0; end
                6'h0E: begin dec_cnrl = 4'b0011; dec_b = imm_zext; dec_shamt = 5'd0; end
                // lui is a left shift of the zero-extended immediate by 16.
                6'h0F: begin dec_cnrl = 4'b1000; dec_b = imm_zext; dec_shamt = 5'd16; end
                default: dec_illegal = 1'b1;
            endcase
        end
    end

    // S1: drive registers load only on an accepted slice and otherwise hold,
    // so the ALU inputs stay frozen while S2 is stalled.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            s1_valid    <= 1'b0;
            s1_trap_en  <= 1'b0;
            s1_illegal  <= 1'b0;
            alu_a_q     <= 32'h0;
            alu_b_q     <= 32'h0;
            alu_cnrl_q  <= CNRL_ILLEGAL;
            alu_shamt_q <= 5'd0;
        end else begin
            s1_valid <= in_fire || (s1_valid && !s1_adv);
            if (in_fire) begin
                s1_trap_en  <= dec_trap_en;
                s1_illegal  <= dec_illegal;
                alu_a_q     <= dec_a;
                alu_b_q     <= dec_b;
                alu_cnrl_q  <= dec_cnrl;
                alu_shamt_q <= dec_shamt;
            end
        end
    end

    assign bus.ALU_A     = alu_a_q;
    assign bus.ALU_B     = alu_b_q;
    assign bus.ALU_CNRL  = alu_cnrl_q;
    assign bus.ALU_SHAMT = alu_shamt_q;

    // An illegal result is forced to a clean zero so writeback never sees
    // garbage from the ALU's bad-function path.
    assign cap_illegal = s1_illegal || bus.ALU_BF;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            out_valid_q <= 1'b0;
            result_q    <= 32'h0;
            zf_q        <= 1'b0;
            nf_q        <= 1'b0;
            trap_q      <= 1'b0;
            illegal_q   <= 1'b0;
        end else if (s1_adv) begin
            out_valid_q <= 1'b1;
            illegal_q   <= cap_illegal;
            if (cap_illegal) begin
                result_q <= 32'h0;
                zf_q     <= 1'b1;
                nf_q     <= 1'b0;
                trap_q   <= 1'b0;
            end else begin
                result_q <= bus.ALU_RESULT;
                zf_q     <= bus.ALU_ZF;
                nf_q     <= bus.ALU_NF;
                trap_q   <= bus.ALU_OF && s1_trap_en;
            end
        end else if (out_valid_q && bus.OUT_READY) begin
            out_valid_q <= 1'b0;
        end
    end

    assign bus.OUT_VALID = out_valid_q;
    assign bus.RESULT    = result_q;
    assign bus.ZF        = zf_q;
    assign bus.NF        = nf_q;
    assign bus.TRAP      = trap_q;
    assign bus.ILLEGAL   = illegal_q;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// tb_alu_issue_ctrl
//   Bench for alu_issue_ctrl. Provides a behavioural 32-bit ALU, a directed
//   vector table, hand-written multi-cycle sequences (reset in flight, stall,
//   variable-shift operand) and a randomized phase scored against an
//   instruction-level reference model.
module tb_alu_issue_ctrl;

    // ---------------- clock / reset ----------------
    logic CLK = 1'b0;
    logic RST_N;
    always #5 CLK = ~CLK;

    alu_issue_ctrl_if bus ();

    alu_issue_ctrl dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_errors = 0;

    // ---------------- behavioural ALU ----------------
    logic [31:0] alu_r;
    logic        alu_of;
    logic        alu_bf;

    always_comb begin
        alu_r  = 32'h0;
        alu_of = 1'b0;
        alu_bf = 1'b0;
        case (bus.ALU_CNRL)
            4'b0000: alu_r = bus.ALU_A & bus.ALU_B;
            4'b0001: alu_r = bus.ALU_A | bus.ALU_B;
            4'b0011: alu_r = bus.ALU_A ^ bus.ALU_B;
            4'b0100: alu_r = ~(bus.ALU_A | bus.ALU_B);
            4'b0010: begin
                alu_r  = bus.ALU_A + bus.ALU_B;
                alu_of = (bus.ALU_A[31] == bus.ALU_B[31]) && (alu_r[31] != bus.ALU_A[31]);
            end
            4'b0110: begin
                alu_r  = bus.ALU_A - bus.ALU_B;
                alu_of = (bus.ALU_A[31] != bus.ALU_B[31]) && (alu_r[31] != bus.ALU_A[31]);
            end
            4'b0111: alu_r = {31'b0, $signed(bus.ALU_A) < $signed(bus.ALU_B)};
            4'b0101: alu_r = {31'b0, bus.ALU_A < bus.ALU_B};
            4'b1000: alu_r = bus.ALU_B << bus.ALU_SHAMT;
            4'b1010: alu_r = bus.ALU_B >> bus.ALU_SHAMT;
            4'b1100: alu_r = $signed(bus.ALU_B) >>> bus.ALU_SHAMT;
            4'b1001: alu_r = bus.ALU_B << bus.ALU_A[4:0];
            4'b1011: alu_r = bus.ALU_B >> bus.ALU_A[4:0];
            4'b1101: alu_r = $signed(bus.ALU_B) >>> bus.ALU_A[4:0];
            default: alu_bf = 1'b1;
        endcase
    end

    assign bus.ALU_RESULT = alu_r;
    assign bus.ALU_ZF     = (alu_r == 32'h0);
    assign bus.ALU_NF     = alu_r[31];
    assign bus.ALU_OF     = alu_of;
    assign bus.ALU_BF     = alu_bf;

    // OUT_READY: 0 = low, 1 = high, 2 = random per cycle
    int   rdy_mode = 1;
    logic rand_bit = 1'b1;
    always @(posedge CLK) begin
        #1;
        rand_bit = 1'($urandom_range(0, 1));
    end
    assign bus.OUT_READY = (rdy_mode == 2) ? rand_bit : (rdy_mode == 1);

    // ---------------- checking ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Instruction-level reference: returns {illegal, trap, nf, zf, result}.
    function automatic logic ovf(input longint s);
        return (s > 64'sd2147483647) || (s < -64'sd2147483648);
    endfunction

    function automatic logic [35:0] ref_exec(input logic [5:0] op, input logic [5:0] fn,
                                             input logic [4:0] sh, input logic [31:0] rs,
                                             input logic [31:0] rt, input logic [15:0] imm);
        logic [31:0] r;
        logic [31:0] se;
        logic [31:0] ze;
        logic        trap;
        logic        ill;
        r    = 32'h0;
        trap = 1'b0;
        ill  = 1'b0;
        se   = {{16{imm[15]}}, imm};
        ze   = {16'h0, imm};
        if (op == 6'h00) begin
            case (fn)
                6'h20: begin r = rs + rt; trap = ovf(longint'($signed(rs)) + longint'($signed(rt))); end
                6'h21: r = rs + rt;
                6'h22: begin r = rs - rt; trap = ovf(longint'($signed(rs)) - longint'($signed(rt))); end
                6'h23: r = rs - rt;
                6'h24: r = rs & rt;
                6'h25: r = rs | rt;
                6'h26: r = rs ^ rt;
                6'h27: r = ~(rs | rt);
                6'h2A: r = ($signed(rs) < $signed(rt)) ? 32'd1 : 32'd0;
                6'h2B: r = (rs < rt) ? 32'd1 : 32'd0;
                6'h00: r = rt << sh;
                6'h02: r = rt >> sh;
                6'h03: r = $signed(rt) >>> sh;
                6'h04: r = rt << rs[4:0];
                6'h06: r = rt >> rs[4:0];
                6'h07: r = $signed(rt) >>> rs[4:0];
                default: ill = 1'b1;
            endcase
        end else begin
            case (op)
                6'h08: begin r = rs + se; trap = ovf(longint'($signed(rs)) + longint'($signed(se))); end
                6'h09: r = rs + se;
                6'h0A: r = ($signed(rs) < $signed(se)) ? 32'd1 : 32'd0;
                6'h0B: r = (rs < se) ? 32'd1 : 32'd0;
                6'h0C: r = rs & ze;
                6'h0D: r = rs | ze;
                6'h0E: r = rs ^ ze;
                6'h0F: r = {imm, 16'h0000};
                default: ill = 1'b1;
            endcase
        end
        if (ill) return {1'b1, 1'b0, 1'b0, 1'b1, 32'h0};
        return {1'b0, trap, r[31], (r == 32'h0), r};
    endfunction

    // ---------------- scoreboard / monitor (negedge) ----------------
    logic [35:0] exp_q[$];
    bit          mon_en = 1'b0;
    int          n_sent = 0;
    int          n_recv = 0;
    logic        prev_stall = 1'b0;
    logic [35:0] prev_out;

    always @(negedge CLK) begin
        if (mon_en && RST_N) begin
            logic [35:0] got;
            logic [35:0] exp;
            got = {bus.ILLEGAL, bus.TRAP, bus.NF, bus.ZF, bus.RESULT};
            if (prev_stall) begin
                check("stall_valid", 32'(bus.OUT_VALID), 32'd1);
                check("stall_result", bus.RESULT, prev_out[31:0]);
                check("stall_flags", 32'(got[35:32]), 32'(prev_out[35:32]));
            end
            if (bus.OUT_READY) check("throughput_in_ready", 32'(bus.IN_READY), 32'd1);
            if (bus.IN_VALID && bus.IN_READY) begin
                exp_q.push_back(ref_exec(bus.OPCODE, bus.FUNCT, bus.SHAMT_IN,
                                         bus.RS_VAL, bus.RT_VAL, bus.IMM));
                n_sent++;
            end
            if (bus.OUT_VALID && bus.OUT_READY) begin
                n_recv++;
                if (exp_q.size() == 0) begin
                    check("sb_unexpected_output", 32'd1, 32'd0);
                end else begin
                    exp = exp_q.pop_front();
                    check("sb_result", got[31:0], exp[31:0]);
                    check("sb_flags", 32'(got[35:32]), 32'(exp[35:32]));
                end
            end
            prev_stall = bus.OUT_VALID && !bus.OUT_READY;
            prev_out   = got;
        end else begin
            prev_stall = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic [5:0] op, input logic [5:0] fn, input logic [4:0] sh,
                         input logic [31:0] rs, input logic [31:0] rt, input logic [15:0] imm);
        bus.OPCODE   = op;
        bus.FUNCT    = fn;
        bus.SHAMT_IN = sh;
        bus.RS_VAL   = rs;
        bus.RT_VAL   = rt;
        bus.IMM      = imm;
    endtask

    // Holds IN_VALID until accepted (bounded); returns at posedge + 1.
    task automatic send_wait(output int cycles);
        bit acc;
        cycles = 0;
        bus.IN_VALID = 1'b1;
        do begin
            @(negedge CLK);
            acc = bus.IN_READY;
            @(posedge CLK);
            #1;
            cycles++;
        end while (!acc && cycles < 200);
        if (!acc) check("accept_timeout", 32'd0, 32'd1);
    endtask

    task automatic random_instr();
        logic [11:0] legal[20];
        logic [11:0] pick;
        logic [31:0] rs;
        logic [31:0] rt;
        legal = '{12'h020, 12'h021, 12'h022, 12'h023, 12'h024, 12'h025, 12'h026,
                  12'h027, 12'h02A, 12'h02B, 12'h000, 12'h002, 12'h003, 12'h004,
                  12'h006, 12'h007, 12'h208, 12'h2CB, 12'h30E, 12'h3C0};
        case ($urandom_range(0, 9))
            0:       pick = 12'hFC0;                       // opcode 0x3F
            1:       pick = 12'h03F;                       // R-type funct 0x3F
            2:       pick = {6'h0F, 6'h00};                // lui
            3:       pick = {6'h09, 6'h00};                // addiu
            4:       pick = {6'h0A, 6'h00};                // slti
            5:       pick = {6'h0D, 6'h00};                // ori
            default: pick = legal[$urandom_range(0, 19)];
        endcase
        rs = $urandom();
        rt = $urandom();
        if ($urandom_range(0, 3) == 0) rs = 32'h7FFFFFFF;
        if ($urandom_range(0, 3) == 0) rt = 32'h80000001;
        drive(pick[11:6], pick[5:0], 5'($urandom_range(0, 31)), rs, rt, 16'($urandom()));
    endtask

    // ---------------- vector table ----------------
    typedef struct packed {
        logic [5:0]  opcode;
        logic [5:0]  funct;
        logic [4:0]  shamt;
        logic [31:0] rs;
        logic [31:0] rt;
        logic [15:0] imm;
        logic [31:0] result;
        logic        zf;
        logic        nf;
        logic        trap;
        logic        illegal;
    } vec_t;

    vec_t vecs[15];

    task automatic run_vec(input vec_t v, input int idx);
        drive(v.opcode, v.funct, v.shamt, v.rs, v.rt, v.imm);
        bus.IN_VALID = 1'b1;
        check($sformatf("v%0d_in_ready", idx), 32'(bus.IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        check($sformatf("v%0d_out_valid_n", idx), 32'(bus.OUT_VALID), 32'd0);
        @(posedge CLK);
        #1;
        check($sformatf("v%0d_out_valid_n1", idx), 32'(bus.OUT_VALID), 32'd1);
        check($sformatf("v%0d_result", idx), bus.RESULT, v.result);
        check($sformatf("v%0d_zf", idx), 32'(bus.ZF), 32'(v.zf));
        check($sformatf("v%0d_nf", idx), 32'(bus.NF), 32'(v.nf));
        check($sformatf("v%0d_trap", idx), 32'(bus.TRAP), 32'(v.trap));
        check($sformatf("v%0d_illegal", idx), 32'(bus.ILLEGAL), 32'(v.illegal));
    endtask

    // ---------------- main sequence ----------------
    initial begin
        int cyc;
        int burst_stall;

        //            op     fn     sh     rs            rt            imm       result        zf nf tr il
        vecs[0]  = '{6'h00, 6'h20, 5'd0,  32'h7FFFFFFF, 32'h00000001, 16'h0000, 32'h80000000, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[1]  = '{6'h00, 6'h21, 5'd0,  32'h7FFFFFFF, 32'h00000001, 16'h0000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{6'h08, 6'h00, 5'd0,  32'h00000005, 32'h00000000, 16'hFFFF, 32'h00000004, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{6'h0B, 6'h00, 5'd0,  32'h00000005, 32'h00000000, 16'hFFFF, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{6'h0C, 6'h00, 5'd0,  32'hFFFFFFFF, 32'h00000000, 16'h8001, 32'h00008001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{6'h0F, 6'h00, 5'd0,  32'h00000000, 32'h00000000, 16'h1234, 32'h12340000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{6'h00, 6'h04, 5'd0,  32'h00000021, 32'h00000001, 16'h0000, 32'h00000002, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{6'h00, 6'h00, 5'd31, 32'h00000000, 32'h80000001, 16'h0000, 32'h80000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{6'h3F, 6'h00, 5'd0,  32'h12345678, 32'h9ABCDEF0, 16'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{6'h00, 6'h22, 5'd0,  32'h80000000, 32'h00000001, 16'h0000, 32'h7FFFFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
        vecs[10] = '{6'h00, 6'h03, 5'd4,  32'h00000000, 32'h80000000, 16'h0000, 32'hF8000000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{6'h00, 6'h2A, 5'd0,  32'hFFFFFFFF, 32'h00000001, 16'h0000, 32'h00000001, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{6'h00, 6'h23, 5'd0,  32'h00000005, 32'h00000005, 16'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{6'h00, 6'h3F, 5'd0,  32'h00000001, 32'h00000002, 16'h0000, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{6'h0E, 6'h00, 5'd0,  32'h0000FFFF, 32'h00000000, 16'hFFFF, 32'h00000000, 1'b1, 1'b0, 1'b0, 1'b0};

        RST_N        = 1'b0;
        bus.IN_VALID = 1'b0;
        drive(6'h00, 6'h00, 5'd0, 32'h0, 32'h0, 16'h0);
        rdy_mode     = 1;
        repeat (3) @(posedge CLK);
        #1;
        check("rst_alu_a", bus.ALU_A, 32'h0);
        check("rst_alu_b", bus.ALU_B, 32'h0);
        check("rst_alu_cnrl", 32'(bus.ALU_CNRL), 32'hF);
        check("rst_alu_shamt", 32'(bus.ALU_SHAMT), 32'h0);
        check("rst_out_valid", 32'(bus.OUT_VALID), 32'h0);
        check("rst_result", bus.RESULT, 32'h0);
        check("rst_flags", 32'({bus.ZF, bus.NF, bus.TRAP, bus.ILLEGAL}), 32'h0);
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("post_rst_in_ready", 32'(bus.IN_READY), 32'd1);

        for (int i = 0; i < 15; i++) run_vec(vecs[i], i);

        // Reset with traffic in flight
        rdy_mode = 0;
        drive(6'h00, 6'h21, 5'd0, 32'd3, 32'd4, 16'h0);
        bus.IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        drive(6'h00, 6'h20, 5'd0, 32'd1, 32'd1, 16'h0);
        @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("rst_mid_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rst_mid_cnrl", 32'(bus.ALU_CNRL), 32'hF);
        check("rst_mid_result", bus.RESULT, 32'h0);
        bus.IN_VALID = 1'b0;
        rdy_mode     = 1;
        @(negedge CLK);
        RST_N = 1'b1;
        @(posedge CLK);
        #1;
        check("rel_in_ready", 32'(bus.IN_READY), 32'd1);
        check("rel_out_valid", 32'(bus.OUT_VALID), 32'd0);
        check("rel_cnrl", 32'(bus.ALU_CNRL), 32'hF);

        // Stall with both stages full, then simultaneous in/out handshake
        rdy_mode = 0;
        drive(6'h00, 6'h20, 5'd0, 32'd3, 32'd4, 16'h0);
        bus.IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        drive(6'h00, 6'h22, 5'd0, 32'd10, 32'd4, 16'h0);
        @(posedge CLK);
        #1;
        drive(6'h00, 6'h26, 5'd0, 32'h000000F0, 32'h000000FF, 16'h0);
        check("stall_out_valid", 32'(bus.OUT_VALID), 32'd1);
        check("stall_first_result", bus.RESULT, 32'd7);
        check("stall_in_ready_low", 32'(bus.IN_READY), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            #1;
            check($sformatf("stall_hold_result_%0d", i), bus.RESULT, 32'd7);
            check($sformatf("stall_hold_cnrl_%0d", i), 32'(bus.ALU_CNRL), 32'h6);
        end
        rdy_mode = 1;
        #1;
        check("unstall_in_ready", 32'(bus.IN_READY), 32'd1);
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        check("unstall_second", bus.RESULT, 32'd6);
        check("unstall_second_valid", 32'(bus.OUT_VALID), 32'd1);
        @(posedge CLK);
        #1;
        check("unstall_third", bus.RESULT, 32'h0000000F);
        @(posedge CLK);
        #1;
        check("drained_out_valid", 32'(bus.OUT_VALID), 32'd0);

        // Variable shift takes only RS[4:0] into A
        drive(6'h00, 6'h04, 5'd0, 32'h00000021, 32'h00000001, 16'h0);
        bus.IN_VALID = 1'b1;
        @(posedge CLK);
        #1;
        bus.IN_VALID = 1'b0;
        check("sllv_alu_a", bus.ALU_A, 32'h1);
        check("sllv_cnrl", 32'(bus.ALU_CNRL), 32'h9);
        @(posedge CLK);
        #1;
        check("sllv_result", bus.RESULT, 32'h2);
        @(posedge CLK);
        #1;

        // Randomized traffic with random OUT_READY
        mon_en   = 1'b1;
        rdy_mode = 2;
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 4) == 0) begin
                bus.IN_VALID = 1'b0;
                @(posedge CLK);
                #1;
            end
            random_instr();
            send_wait(cyc);
        end
        bus.IN_VALID = 1'b0;

        // Eight back-to-back with OUT_READY held high: no stalls allowed
        rdy_mode    = 1;
        burst_stall = 0;
        for (int i = 0; i < 8; i++) begin
            random_instr();
            send_wait(cyc);
            burst_stall += cyc - 1;
        end
        bus.IN_VALID = 1'b0;
        check("burst_stall_cycles", 32'(burst_stall), 32'd0);

        cyc = 0;
        while (exp_q.size() != 0 && cyc < 50) begin
            @(posedge CLK);
            #1;
            cyc++;
        end
        check("drain_queue_empty", 32'(exp_q.size()), 32'd0);
        check("sent_vs_received", 32'(n_recv), 32'(n_sent));
        mon_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/alu_issue_ctrl.md
# alu_issue_ctrl

Issue and capture stage wrapped around the 32-bit ALU. It accepts a decoded MIPS instruction slice (opcode, funct, shamt, register values, immediate) over a valid/ready handshake. It produces the ALU's A, B, CNRL and SHAMT inputs from registers, then captures the ALU result and flags into an output register with its own valid/ready handshake. It sits between the ID/EX boundary and writeback, owning opcode/funct-to-CNRL decoding and overflow trap qualification.

## Interface
- No parameters; datapath fixed at 32 bits.
- CLK  in  1  rising-edge clock
- RST_N  in  1  asynchronous, active-low reset
- IN_VALID  in  1  instruction slice valid
- IN_READY  out  1  stage can accept this cycle
- OPCODE  in  6  instruction bits [31:26]
- FUNCT  in  6  instruction bits [5:0]
- SHAMT_IN  in  5  instruction bits [10:6]
- RS_VAL  in  32  rs register value
- RT_VAL  in  32  rt register value
- IMM  in  16  immediate field
- ALU_A, ALU_B  out  32  registered ALU operands
- ALU_CNRL  out  4  registered ALU control code
- ALU_SHAMT  out  5  registered ALU shift amount
- ALU_RESULT  in  32  ALU output
- ALU_ZF, ALU_NF, ALU_OF, ALU_BF  in  1  ALU flags
- OUT_VALID  out  1  result register valid
- OUT_READY  in  1  consumer accepts result
- RESULT  out  32  captured result
- ZF, NF  out  1  captured zero and negative flags
- TRAP  out  1  signed overflow on add, sub or addi
- ILLEGAL  out  1  undecodable instruction

## Operation
- Two registered stages:
  - S1 holds the ALU drive registers plus s1_valid, s1_trap_en and s1_illegal.
  - S2 holds RESULT, ZF, NF, TRAP, ILLEGAL and OUT_VALID.
- R-type decode (OPCODE=0x00): A=RS_VAL, B=RT_VAL, SHAMT=SHAMT_IN.
  - FUNCT to CNRL: 0x20 add→0010 (trap_en), 0x21 addu→0010, 0x22 sub→0110 (trap_en), 0x23 subu→0110.
  - 0x24→0000, 0x25→0001, 0x26→0011, 0x27→0100, 0x2A→0111, 0x2B→0101.
  - Shifts: 0x00→1000, 0x02→1010, 0x03→1100, 0x04→1001, 0x06→1011, 0x07→1101.
  - For variable shifts (0x04/0x06/0x07), A={27'b0, RS_VAL[4:0]}.
- I-type decode: A=RS_VAL, SHAMT=0.
  - Sign-extended IMM as B: 0x08 addi→0010 (trap_en), 0x09 addiu→0010, 0x0A slti→0111, 0x0B sltiu→0101.
  - Zero-extended IMM as B: 0x0C andi→0000, 0x0D ori→0001, 0x0E xori→0011.
  - 0x0F lui: CNRL=1000, B=zero-extended IMM, SHAMT=16.
- Any other OPCODE/FUNCT: CNRL=4'b1111, s1_illegal=1. A, B and SHAMT are loaded as for R-type.
- Capture into S2:
  - RESULT=ALU_RESULT, ZF=ALU_ZF, NF=ALU_NF, TRAP=ALU_OF & s1_trap_en, ILLEGAL=s1_illegal|ALU_BF.
  - When ILLEGAL is captured as 1: RESULT=0, ZF=1, NF=0, TRAP=0.
- The S1 registers load only on an input handshake; they hold their value otherwise, including when S1 empties.

## Timing
- Reset (asynchronous, takes effect immediately):
  - ALU_A=0, ALU_B=0, ALU_CNRL=4'b1111, ALU_SHAMT=0.
  - s1_valid=0, OUT_VALID=0, RESULT=0, ZF=0, NF=0, TRAP=0, ILLEGAL=0.
  - IN_READY=1 once RST_N is high.
- Handshake rules:
  - s2_free = !OUT_VALID | OUT_READY.
  - s1_adv = s1_valid & s2_free.
  - IN_READY = !s1_valid | s2_free (combinational, no dependence on IN_VALID).
- Latency: a handshake at edge N loads S1. S2 captures at edge N+1 if s2_free, and OUT_VALID is high after edge N+1. Throughput is one instruction per cycle.
- Stall: while OUT_VALID & !OUT_READY, RESULT and all flags stay stable and S1 holds. The ALU inputs are unchanged, so the captured result equals the held ALU output.
- OUT_VALID clears on an output handshake unless s1_adv loads new data on the same edge.
- Simultaneous input handshake and s1_adv on one edge is legal: S1 takes new data and S2 takes old S1.
- RST_N low mid-operation discards both stages. No output handshake completes for in-flight instructions.

## Test plan
- Reset with traffic in flight, then release: OUT_VALID=0, ALU_CNRL=1111, IN_READY=1 in the first cycle after release.
- add: RS=0x7FFFFFFF, RT=1, FUNCT=0x20 → RESULT=0x80000000, NF=1, TRAP=1, two edges after accept. Same operands with addu → TRAP=0.
- addi: RS=5, IMM=0xFFFF → RESULT=4. sltiu: RS=5, IMM=0xFFFF → RESULT=1. andi: RS=0xFFFFFFFF, IMM=0x8001 → RESULT=0x00008001. lui: IMM=0x1234 → RESULT=0x12340000.
- sllv: RS=0x00000021, RT=1 → ALU_A=1, RESULT=2. sll: RT=0x80000001, SHAMT=31 → RESULT=0x80000000.
- Illegal: OPCODE=0x3F → ILLEGAL=1, RESULT=0, ZF=1. The next legal instruction clears ILLEGAL.
- Back-to-back 8 instructions with OUT_READY toggled randomly: no loss or duplication, results in order, RESULT stable while stalled, full throughput when OUT_READY=1.
